// File: rtl/ysyx_23060062_alu_pkg.sv
// Shared definitions for the serial ALU units.
// Contents: subtract-unit op encodings, FSM state encodings, default widths
// and helpers that derive the cycle count and counter width.
package ysyx_23060062_alu_pkg;

    // Operation encodings for ysyx_23060062_sub_serial; 2'b11 behaves as SUB.
    localparam logic [1:0] SUB_OP_SUB  = 2'b00;
    localparam logic [1:0] SUB_OP_SLT  = 2'b01;
    localparam logic [1:0] SUB_OP_SLTU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    localparam int unsigned SUB_XLEN  = 32;
    localparam int unsigned SUB_CHUNK = 4;

    // Number of chunk cycles needed to cover the whole operand.
    function automatic int unsigned sub_ncyc(input int unsigned xlen, input int unsigned chunk);
        return xlen / chunk;
    endfunction

    // Counter width; at least one bit even for a single-cycle configuration.
    function automatic int unsigned sub_cnt_w(input int unsigned ncyc);
        return (ncyc > 1) ? $clog2(ncyc) : 1;
    endfunction

    localparam int unsigned SUB_NCYC  = sub_ncyc(SUB_XLEN, SUB_CHUNK);
    localparam int unsigned SUB_CNT_W = sub_cnt_w(SUB_NCYC);

endpackage

// File: rtl/ysyx_23060062_sub_chunk.sv
// CHUNK-bit combinational subtract slice: diff = a + ~b + cin.
// Ports:
//   a, b  - minuend / subtrahend slices
//   cin   - incoming carry (1 for the first slice of a subtraction)
//   diff  - slice difference
//   cout  - outgoing carry (0 means a borrow out of this slice)
module ysyx_23060062_sub_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] diff,
    output logic             cout
);

    logic [CHUNK-1:0] nb;
    logic [CHUNK:0]   c;

    assign nb   = ~b;
    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign diff[i]  = a[i] ^ nb[i] ^ c[i];
        assign c[i + 1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/ysyx_23060062_sub_serial.sv
// Multi-cycle serial SUB / SLT / SLTU unit, CHUNK bits per cycle, LSB first.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - request handshake (op, src1, src2)
//   out_valid / out_ready- result handshake (result, borrow[, zero])
//   result               - difference, or {0, lt} for compares
//   borrow               - 1 when src1 < src2 unsigned
// Optional: define YSYX_23060062_SUB_ZERO_EN to add output 'zero', set when
// the full difference is zero regardless of op.
module ysyx_23060062_sub_serial
    import ysyx_23060062_alu_pkg::*;
#(
    parameter int unsigned XLEN  = SUB_XLEN,
    parameter int unsigned CHUNK = SUB_CHUNK
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
`ifdef YSYX_23060062_SUB_ZERO_EN
    output logic            zero,
`endif
    output logic            borrow
);

    localparam int unsigned     NCYC     = sub_ncyc(XLEN, CHUNK);
    localparam int unsigned     CNT_W    = sub_cnt_w(NCYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    sub_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, result_q, result_d;
    logic            borrow_q, borrow_d, out_valid_q, out_valid_d;
`ifdef YSYX_23060062_SUB_ZERO_EN
    logic            zero_q, zero_d;
`endif

    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_cout;
    logic             lt_slt;

    ysyx_23060062_sub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_q[cnt_q * CHUNK +: CHUNK]),
        .b    (b_q[cnt_q * CHUNK +: CHUNK]),
        .cin  (carry_q),
        .diff (chunk_diff),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        result_d    = result_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        lt_slt      = 1'b0;
`ifdef YSYX_23060062_SUB_ZERO_EN
        zero_d      = zero_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    carry_d = 1'b1;
                    cnt_d   = '0;
`ifdef YSYX_23060062_SUB_ZERO_EN
                    zero_d  = 1'b1;
`endif
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                diff_d[cnt_q * CHUNK +: CHUNK] = chunk_diff;
                carry_d = chunk_cout;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef YSYX_23060062_SUB_ZERO_EN
                zero_d  = zero_q & ~(|chunk_diff);
`endif
                if (cnt_q == CNT_LAST) begin
                    // Operand signs differ: result sign is meaningless, a's sign decides.
                    lt_slt = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? a_q[XLEN-1] : diff_d[XLEN-1];
                    borrow_d = ~chunk_cout;
                    if (op_q == SUB_OP_SLT) begin
                        result_d = {{(XLEN-1){1'b0}}, lt_slt};
                    end else if (op_q == SUB_OP_SLTU) begin
                        result_d = {{(XLEN-1){1'b0}}, ~chunk_cout};
                    end else begin
                        result_d = diff_d;
                    end
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= SUB_OP_SUB;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            result_q    <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef YSYX_23060062_SUB_ZERO_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            result_q    <= result_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
`ifdef YSYX_23060062_SUB_ZERO_EN
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign borrow    = borrow_q;
`ifdef YSYX_23060062_SUB_ZERO_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_ysyx_23060062_sub_serial.sv
// Directed self-checking bench for ysyx_23060062_sub_serial (XLEN=32, CHUNK=4).
module tb_ysyx_23060062_sub_serial;

    localparam int LAT = 9;  // accept cycle T -> out_valid first high at T+NCYC+1

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        borrow;
`ifdef YSYX_23060062_SUB_ZERO_EN
    logic        zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060062_sub_serial #(
        .XLEN  (32),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef YSYX_23060062_SUB_ZERO_EN
        .zero      (zero),
`endif
        .borrow    (borrow)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; the unit is expected to be idle.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns the cycle index (relative to the accept cycle) where out_valid rises.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_borrow, input logic exp_zero);
        int lat;
        check1({tag, "_in_ready"}, in_ready, 1'b1);
        start_op(o, a, b);
        wait_done(lat);
        check32({tag, "_latency"}, 32'(lat), 32'(LAT));
        check32({tag, "_result"}, result, exp_res);
        check1({tag, "_borrow"}, borrow, exp_borrow);
`ifdef YSYX_23060062_SUB_ZERO_EN
        check1({tag, "_zero"}, zero, exp_zero);
`else
        if (exp_zero === 1'bx) $display("unexpected x flag in %s", tag);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check1({tag, "_drop_valid"}, out_valid, 1'b0);
        check1({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        src1      = '0;
        src2      = '0;
        tick();
        tick();
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check32("rst_result", result, 32'h0);
        check1("rst_borrow", borrow, 1'b0);
`ifdef YSYX_23060062_SUB_ZERO_EN
        check1("rst_zero", zero, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic arithmetic and compares.
        run_op("sub_5_3", 2'b00, 32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0);
        run_op("sub_3_5", 2'b00, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("sub_min_1", 2'b00, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        run_op("slt_m1_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0, 1'b0);
        run_op("sltu_m1_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0);
        run_op("slt_max_min", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        run_op("sltu_3_5", 2'b10, 32'd3, 32'd5, 32'h1, 1'b1, 1'b0);
        run_op("rsv_5_3", 2'b11, 32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0);
        run_op("zero_eq", 2'b00, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b1);
        run_op("zero_ne", 2'b00, 32'h1234, 32'h1233, 32'h1, 1'b0, 1'b0);

        // Backpressure: hold result for 5 cycles, ignore a request meanwhile.
        start_op(2'b00, 32'd100, 32'd1);
        wait_done(lat);
        check32("bp_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            check32("bp_result_stable", result, 32'd99);
            check1("bp_valid_held", out_valid, 1'b1);
            check1("bp_in_ready_low", in_ready, 1'b0);
            if (i == 1) begin
                op       = 2'b00;
                src1     = 32'd50;
                src2     = 32'd7;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check1("bp_drop_valid", out_valid, 1'b0);
        check1("bp_idle_ready", in_ready, 1'b1);
        run_op("bp_next", 2'b00, 32'd9, 32'd2, 32'd7, 1'b0, 1'b0);

        // Reset in the middle of BUSY discards the operation.
        start_op(2'b00, 32'd20, 32'd5);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check1("midrst_in_ready", in_ready, 1'b1);
        check1("midrst_out_valid", out_valid, 1'b0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check32("midrst_no_valid", 32'(seen), 32'd0);
        run_op("after_rst", 2'b00, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
